add16_seq: RTL and testbench

ADD16_SEQ -- requirements
Module: add16_seq

---
 rtl/add16_seq_pkg.sv | 18 +
 rtl/add16_seq_if.sv | 34 +++
 rtl/cpa4_slice.sv | 23 ++
 rtl/add16_seq.sv | 128 ++++++++++++
 tb/tb_add16_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/add16_seq_pkg.sv
// Shared types and default constants for the sequential slice adder.
package add16_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/add16_seq_if.sv
// Two-requester operand/result bus of the sequential adder.
interface add16_seq_if
  import add16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             done;
  req_id_t          done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output ack0, ack1, busy, done, done_id, sum, cout
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  ack0, ack1, busy, done, done_id, sum, cout
  );

endinterface

// File: rtl/cpa4_slice.sv
// W-bit ripple-carry adder slice made of one full-adder cell per bit.
module cpa4_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);

  logic [W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[W];

endmodule

// File: rtl/add16_seq.sv
// Round-robin two-requester adder that sums one SLICE-bit slice per cycle.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures operands
// RUN   | adding slice cnt into the accumulator, carry kept between cycles
// DONE  | result on sum/cout, done pulses for one cycle
module add16_seq
  import add16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input logic         clk,
  input logic         rst_n,
  add16_seq_if.slave  bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic             carry_q, cout_q, ack0_q, ack1_q;
  req_id_t          gnt_q, gnt_d, last_q, done_id_q;
  logic [CW-1:0]    cnt_q;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_c;
  logic             start, last_slice, busy, done;

  assign start      = (state_q == IDLE) && (bus.req0 || bus.req1);
  assign last_slice = (cnt_q == CW'(NSL - 1));

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_d = REQ0;
    if (bus.req0 && bus.req1) gnt_d = ~last_q;
    else if (bus.req1)        gnt_d = REQ1;
  end

  assign sl_a = a_q[int'(cnt_q) * SLICE +: SLICE];
  assign sl_b = b_q[int'(cnt_q) * SLICE +: SLICE];

  cpa4_slice #(.W(SLICE)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .s     (sl_s),
    .c_out (sl_c)
  );

  always_comb begin
    acc_d = acc_q;
    acc_d[int'(cnt_q) * SLICE +: SLICE] = sl_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= REQ0;
      done_id_q <= REQ0;
      last_q    <= REQ1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          gnt_q   <= gnt_d;
          last_q  <= gnt_d;
          a_q     <= (gnt_d == REQ1) ? bus.a1 : bus.a0;
          b_q     <= (gnt_d == REQ1) ? bus.b1 : bus.b0;
          carry_q <= (gnt_d == REQ1) ? bus.cin1 : bus.cin0;
          cnt_q   <= '0;
          ack0_q  <= (gnt_d == REQ0);
          ack1_q  <= (gnt_d == REQ1);
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= sl_c;
          cnt_q   <= cnt_q + CW'(1);
          // Final slice: publish the merged accumulator so sum never shows partials.
          if (last_slice) begin
            sum_q     <= acc_d;
            cout_q    <= sl_c;
            done_id_q <= gnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.done_id = done_id_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_add16_seq.sv
// Directed and soak bench for add16_seq; results checked by a queue-based scoreboard.
module tb_add16_seq;
  import add16_seq_pkg::*;

  typedef struct {
    bit          id;
    logic [16:0] res;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  bit   last_srv;
  exp_t sbq[$];

  add16_seq_if #(.WIDTH(16)) bus ();

  add16_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on every done pulse, otherwise the result registers must hold.
  initial begin : monitor
    exp_t    e;
    logic [15:0] h_sum;
    logic        h_cout;
    logic        h_id;
    h_sum = '0; h_cout = 1'b0; h_id = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        h_sum = '0; h_cout = 1'b0; h_id = 1'b0;
      end else if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("done_id", 64'(bus.done_id), 64'(e.id));
          chk("result", 64'({bus.cout, bus.sum}), 64'(e.res));
        end
        h_sum = bus.sum; h_cout = bus.cout; h_id = bus.done_id;
      end else begin
        chk("hold", 64'({bus.done_id, bus.cout, bus.sum}), 64'({h_id, h_cout, h_sum}));
      end
    end
  end

  task automatic wait_ack(input bit who);
    bit got, oth;
    got = 1'b0; oth = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk);
      #1;
      got = who ? bus.ack1 : bus.ack0;
      if (who ? bus.ack0 : bus.ack1) oth = 1'b1;
    end
    chk(who ? "ack1_seen" : "ack0_seen", 64'(got), 64'(1));
    chk("ack_exclusive", 64'(oth), 64'(0));
  endtask

  task automatic wait_done(input bit who, input int start_n);
    int  n;
    bit  oth;
    n = start_n; oth = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (who ? bus.ack0 : bus.ack1) oth = 1'b1;
      if (bus.done) break;
    end
    chk("latency", 64'(n), 64'(4));
    chk("no_ack_while_busy", 64'(oth), 64'(0));
  endtask

  task automatic drop(input bit who);
    @(negedge clk);
    if (who) bus.req1 = 1'b0;
    else     bus.req0 = 1'b0;
  endtask

  task automatic serve(input bit r0, input bit r1,
                       input logic [15:0] x0, input logic [15:0] y0, input bit c0,
                       input logic [15:0] x1, input logic [15:0] y1, input bit c1,
                       input logic [16:0] e0, input logic [16:0] e1);
    bit first;
    int nops;
    first = (r0 && r1) ? ~last_srv : (r0 ? 1'b0 : 1'b1);
    nops  = (r0 && r1) ? 2 : 1;
    for (int k = 0; k < nops; k++) begin
      bit w;
      w = (k == 0) ? first : ~first;
      sbq.push_back('{id: w, res: (w ? e1 : e0)});
    end
    @(negedge clk);
    bus.a0 = x0; bus.b0 = y0; bus.cin0 = c0;
    bus.a1 = x1; bus.b1 = y1; bus.cin1 = c1;
    bus.req0 = r0; bus.req1 = r1;
    for (int k = 0; k < nops; k++) begin
      bit w;
      w = (k == 0) ? first : ~first;
      wait_ack(w);
      drop(w);
      wait_done(w, 0);
    end
    last_srv = (nops == 2) ? ~first : first;
  endtask

  initial begin : stim
    int          ops;
    int          m;
    logic [15:0] x0, y0, x1, y1;
    bit          c0, c1;
    n_vec = 0; n_err = 0; last_srv = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        64'({bus.busy, bus.done, bus.ack0, bus.ack1, bus.done_id, bus.cout, bus.sum}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tie straight after reset: req0 first.
    serve(1, 1, 16'h1111, 16'h2222, 0, 16'hA0A0, 16'h0505, 1, 17'h03333, 17'h0A5A6);
    serve(1, 0, 16'h1234, 16'h4321, 1, 16'h0000, 16'h0000, 0, 17'h05556, 17'h00000);
    // req0 served last, so this tie goes to req1 first.
    serve(1, 1, 16'h7FFF, 16'h0001, 0, 16'h0F00, 16'h00F0, 1, 17'h08000, 17'h00FF1);
    serve(0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0001, 0, 17'h00000, 17'h10000);

    // req1 raised while a req0 operation is running.
    sbq.push_back('{id: 1'b0, res: 17'h01F1F});
    sbq.push_back('{id: 1'b1, res: 17'h10001});
    @(negedge clk);
    bus.a0 = 16'h0F0F; bus.b0 = 16'h1010; bus.cin0 = 1'b0;
    bus.a1 = 16'h8000; bus.b1 = 16'h8000; bus.cin1 = 1'b1;
    bus.req0 = 1'b1;
    wait_ack(1'b0);
    drop(1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.req1 = 1'b1;
    wait_done(1'b0, 1);
    wait_ack(1'b1);
    drop(1'b1);
    wait_done(1'b1, 0);
    last_srv = 1'b1;

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    bus.a0 = 16'hABCD; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
    bus.req0 = 1'b1;
    wait_ack(1'b0);
    drop(1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs",
        64'({bus.busy, bus.done, bus.ack0, bus.ack1, bus.done_id, bus.cout, bus.sum}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_srv = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_abort", 64'(bus.done), 64'(0));
    end
    serve(1, 0, 16'h00FF, 16'h0001, 0, 16'h0000, 16'h0000, 0, 17'h00100, 17'h00000);

    // Soak on both requesters, ties included.
    ops = 0;
    while (ops < 1000) begin
      m  = int'($urandom_range(1, 3));
      x0 = 16'($urandom); y0 = 16'($urandom); c0 = 1'($urandom_range(0, 1));
      x1 = 16'($urandom); y1 = 16'($urandom); c1 = 1'($urandom_range(0, 1));
      serve(m[0], m[1], x0, y0, c0, x1, y1, c1,
            {1'b0, x0} + {1'b0, y0} + 17'(c0),
            {1'b0, x1} + {1'b0, y1} + 17'(c1));
      ops += (m == 3) ? 2 : 1;
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
